// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: CPU FSM encoding, screen geometry defaults
// and the video-slot decode used by both the arbiter and the address generator.
package vram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } cpu_state_e;

    localparam logic [15:0] SCREEN_BASE_DEF = 16'h7000;
    localparam int          COLS_DEF        = 100;
    localparam int          ROW_H_DEF       = 10;

    // One character fetch every 8 pixels inside the visible window.
    function automatic logic video_slot(input logic [10:0] cx, input logic [10:0] cy,
                                        input int vis_w, input int vis_h);
        return (cx[2:0] == 3'd0) && (int'(cx) < vis_w) && (int'(cy) < vis_h);
    endfunction

endpackage

// File: rtl/vram_addr_gen.sv
// Character-cell address generator: walks char_addr along a row, reloads it from
// row_base at the end of each visible line and advances row_base once per character row.
module vram_addr_gen
    import vram_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] SCREEN_BASE = ADDR_W'(SCREEN_BASE_DEF),
    parameter int                COLS        = COLS_DEF,
    parameter int                ROW_H       = ROW_H_DEF,
    parameter int                VIS_W       = 800,
    parameter int                VIS_H       = 600
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       counter_x_i,
    input  logic [10:0]       counter_y_i,
    input  logic              slot_i,
    output logic [ADDR_W-1:0] fetch_addr_o,
    output logic [3:0]        char_line_o
);

    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
    localparam logic [3:0]        LAST_L = 4'(ROW_H - 1);

    logic [ADDR_W-1:0] char_addr_q, char_addr_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [3:0]        char_line_q, char_line_d;
    logic [ADDR_W-1:0] row_next_s;
    logic [3:0]        line_next_s;
    logic              frame_start_s;
    logic              line_end_s;

    assign frame_start_s = (counter_x_i == 11'd0) && (counter_y_i == 11'd0);
    assign line_end_s    = (int'(counter_x_i) == VIS_W) && (int'(counter_y_i) < VIS_H);

    // The first fetch of a frame must already use SCREEN_BASE, whatever the last frame left behind.
    assign fetch_addr_o = frame_start_s ? SCREEN_BASE : char_addr_q;
    assign char_line_o  = char_line_q;

    // Row/scanline advance taken at the end of each visible line.
    always_comb begin
        if (char_line_q == LAST_L) begin
            row_next_s  = row_base_q + COLS_A;
            line_next_s = 4'd0;
        end else begin
            row_next_s  = row_base_q;
            line_next_s = char_line_q + 4'd1;
        end
    end

    // Next-state selection: frame start beats line end, which beats the per-slot increment.
    always_comb begin
        char_addr_d = char_addr_q;
        row_base_d  = row_base_q;
        char_line_d = char_line_q;
        if (frame_start_s) begin
            row_base_d  = SCREEN_BASE;
            char_line_d = 4'd0;
            char_addr_d = slot_i ? (SCREEN_BASE + ONE_A) : SCREEN_BASE;
        end else if (line_end_s) begin
            char_addr_d = row_next_s;
            row_base_d  = row_next_s;
            char_line_d = line_next_s;
        end else if (slot_i) begin
            char_addr_d = char_addr_q + ONE_A;
        end else begin
            char_addr_d = char_addr_q;
        end
    end

    // Address generator state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_addr_q <= SCREEN_BASE;
            row_base_q  <= SCREEN_BASE;
            char_line_q <= 4'd0;
        end else begin
            char_addr_q <= char_addr_d;
            row_base_q  <= row_base_d;
            char_line_q <= char_line_d;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one synchronous VRAM port between the character fetcher (always wins) and a CPU.
// Build option VRAM_ARB_BLANK_ONLY_EN limits CPU accesses to the blanking intervals.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] SCREEN_BASE = ADDR_W'(SCREEN_BASE_DEF),
    parameter int                COLS        = COLS_DEF,
    parameter int                ROW_H       = ROW_H_DEF,
    parameter int                VIS_W       = 800,
    parameter int                VIS_H       = 600
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       counter_x,
    input  logic [10:0]       counter_y,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        char_code,
    output logic              char_valid,
    output logic [3:0]        char_line
);

    cpu_state_e        state_q, state_d;
    logic              slot_s;
    logic              cpu_ok_s;
    logic              issue_s;
    logic [ADDR_W-1:0] fetch_addr_s;
    logic              vid_pend_q;
    logic              char_valid_q;
    logic [7:0]        char_code_q;
    logic              cpu_ack_q;
    logic [7:0]        cpu_rdata_q;
    logic              cpu_we_q;

    assign slot_s = video_slot(counter_x, counter_y, VIS_W, VIS_H);

`ifdef VRAM_ARB_BLANK_ONLY_EN
    logic blank_s;
    assign blank_s  = (int'(counter_x) >= VIS_W) || (int'(counter_y) >= VIS_H);
    assign cpu_ok_s = blank_s && !slot_s;
`else
    assign cpu_ok_s = !slot_s;
`endif

    assign issue_s = (state_q == ST_IDLE) && cpu_req && cpu_ok_s;

    vram_addr_gen #(
        .ADDR_W      (ADDR_W),
        .SCREEN_BASE (SCREEN_BASE),
        .COLS        (COLS),
        .ROW_H       (ROW_H),
        .VIS_W       (VIS_W),
        .VIS_H       (VIS_H)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .counter_x_i  (counter_x),
        .counter_y_i  (counter_y),
        .slot_i       (slot_s),
        .fetch_addr_o (fetch_addr_s),
        .char_line_o  (char_line)
    );

    // CPU access FSM: IDLE -> ISSUE -> DONE -> IDLE, never aborted once issued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_s) state_d = ST_ISSUE;
                else         state_d = ST_IDLE;
            end
            ST_ISSUE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Memory port mux; the bus is forced quiet while reset is held.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = 8'd0;
        if (!rst_n) begin
            mem_en = 1'b0;
        end else if (slot_s) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr_s;
        end else if (issue_s) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else begin
            mem_en = 1'b0;
        end
    end

    // Pipeline registers: RAM data returns in the cycle after issue and is registered once more.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vid_pend_q   <= 1'b0;
            char_valid_q <= 1'b0;
            char_code_q  <= 8'd0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= 8'd0;
            cpu_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            vid_pend_q   <= slot_s;
            char_valid_q <= vid_pend_q;
            cpu_ack_q    <= (state_q == ST_ISSUE);
            if (vid_pend_q) char_code_q <= mem_rdata;
            if (issue_s) cpu_we_q <= cpu_we;
            if ((state_q == ST_ISSUE) && !cpu_we_q) cpu_rdata_q <= mem_rdata;
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign char_valid = char_valid_q;
    assign char_code  = char_code_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: drives a shortened raster (lines 0..11, then one blank line),
// models the RAM, and checks every cycle against a formula-based reference.
module tb_vram_arbiter;

    localparam int          VIS_W  = 800;
    localparam int          VIS_H  = 600;
    localparam int          COLS   = 100;
    localparam int          ROW_H  = 10;
    localparam int          H_LAST = 807;
    localparam logic [15:0] BASE   = 16'h7000;
`ifdef VRAM_ARB_BLANK_ONLY_EN
    localparam bit BLANK_ONLY = 1'b1;
`else
    localparam bit BLANK_ONLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] counter_x, counter_y;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [7:0]  char_code;
    logic        char_valid;
    logic [3:0]  char_line;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit restart = 1'b1;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk(clk), .rst_n(rst_n), .counter_x(counter_x), .counter_y(counter_y),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .char_code(char_code), .char_valid(char_valid),
        .char_line(char_line)
    );

    // RAM: untouched cells hold a fixed address pattern.
    logic [7:0] ram  [0:65535];
    bit         ramv [0:65535];

    function automatic logic [7:0] ram_rd(input logic [15:0] a);
        return ramv[a] ? ram[a] : (a[7:0] ^ a[15:8]);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram_rd(mem_addr);
            if (mem_we) begin
                ram[mem_addr]  <= mem_wdata;
                ramv[mem_addr] <= 1'b1;
            end
        end
    end

    // Raster: x 0..807 per line, lines 0..11 then 600, then next frame.
    initial begin
        counter_x = 11'd807;
        counter_y = 11'd600;
        forever begin
            @(posedge clk); #1;
            if (restart) begin
                counter_x = 11'd807;
                counter_y = 11'd600;
            end else if (int'(counter_x) == H_LAST) begin
                counter_x = 11'd0;
                if (counter_y == 11'd11)       counter_y = 11'd600;
                else if (counter_y == 11'd600) counter_y = 11'd0;
                else                           counter_y = counter_y + 11'd1;
            end else begin
                counter_x = counter_x + 11'd1;
            end
        end
    end

    // Reference model: fetch address from row/column arithmetic, CPU ack two cycles after issue.
    typedef struct { int due; logic [7:0] d; } vent_t;
    vent_t vq[$];
    int cyc, m_free, m_ack;
    bit m_rd;
    logic [7:0] m_rdata;

    always @(negedge clk) begin
        int xi, yi;
        bit slot, permit, ok, e_en, e_we, chk_wd, e_cv, e_ack;
        logic [15:0] e_addr;
        logic [7:0] e_wd, e_cc;
        if (!chk_en) begin
            cyc = 0; m_free = 0; m_ack = -1; m_rd = 1'b0; m_rdata = 8'd0;
            vq.delete();
        end else begin
            cyc++;
            xi = int'(counter_x);
            yi = int'(counter_y);
            slot   = (xi % 8 == 0) && (xi < VIS_W) && (yi < VIS_H);
            permit = BLANK_ONLY ? ((xi >= VIS_W) || (yi >= VIS_H)) : !slot;
            e_en = 1'b0; e_we = 1'b0; chk_wd = 1'b0; e_addr = 16'd0; e_wd = 8'd0; e_cc = 8'd0;
            if (slot) begin
                e_en   = 1'b1;
                e_addr = BASE + 16'((yi / ROW_H) * COLS + xi / 8);
                vq.push_back('{due: cyc + 2, d: ram_rd(e_addr)});
            end else if (cyc >= m_free && cpu_req && permit) begin
                e_en = 1'b1; e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; chk_wd = cpu_we;
                m_ack = cyc + 2; m_free = cyc + 3; m_rd = !cpu_we; m_rdata = ram_rd(cpu_addr);
            end
            e_cv = (vq.size() > 0) && (vq[0].due == cyc);
            if (e_cv) begin
                e_cc = vq[0].d;
                void'(vq.pop_front());
            end
            e_ack = (cyc == m_ack);
            ok = (mem_en === e_en) && (mem_we === e_we) && (!e_en || mem_addr === e_addr) &&
                 (!chk_wd || mem_wdata === e_wd) && (char_valid === e_cv) &&
                 (!e_cv || char_code === e_cc) && (cpu_ack === e_ack) &&
                 (!(e_ack && m_rd) || cpu_rdata === m_rdata);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL cycle x=%0d y=%0d: got en=%b we=%b addr=%h wd=%h cv=%b cc=%h ack=%b rd=%h, expected en=%b we=%b addr=%h wd=%h cv=%b cc=%h ack=%b rd=%h",
                         xi, yi, mem_en, mem_we, mem_addr, mem_wdata, char_valid, char_code, cpu_ack, cpu_rdata,
                         e_en, e_we, e_addr, e_wd, e_cv, e_cc, e_ack, m_rdata);
            end
            if (xi == 400 && yi < VIS_H) begin
                checks++;
                if (char_line !== 4'(yi % ROW_H)) begin
                    errors++;
                    $display("FAIL char_line y=%0d: got %0d expected %0d", yi, char_line, yi % ROW_H);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_xy(input int x, input int y);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(int'(counter_x) == x && int'(counter_y) == y) && n < 20000);
        if (n >= 20000) begin
            checks++; errors++;
            $display("FAIL wait_xy(%0d,%0d): position never reached", x, y);
        end
    endtask

    task automatic cpu_go(input logic we, input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic cpu_wait_ack(output int ack_x, output logic [7:0] rd);
        int n;
        ack_x = -1; rd = 8'd0; n = 0;
        while (n < 3000 && ack_x < 0) begin
            @(negedge clk);
            n++;
            if (cpu_ack) begin
                ack_x = int'(counter_x);
                rd = cpu_rdata;
            end
        end
        if (ack_x < 0) begin
            checks++; errors++;
            $display("FAIL cpu_ack timeout: got no ack, required ack within 3000 cycles");
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    typedef struct {
        int y; int x; logic we; logic [15:0] addr; logic [7:0] wd; int ack_x; logic [7:0] rd;
    } vec_t;

    initial begin
        vec_t vt [6];
        int ax;
        logic [7:0] rd;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'd0; cpu_wdata = 8'd0;

        vt[0] = '{y: 0,   x: 3,   we: 1'b1, addr: 16'h1234, wd: 8'hA5, ack_x: BLANK_ONLY ? 802 : 5,   rd: 8'h00};
        vt[1] = '{y: 1,   x: 20,  we: 1'b0, addr: 16'h1234, wd: 8'h00, ack_x: BLANK_ONLY ? 802 : 22,  rd: 8'hA5};
        vt[2] = '{y: 2,   x: 8,   we: 1'b0, addr: 16'h7005, wd: 8'h00, ack_x: BLANK_ONLY ? 802 : 11,  rd: 8'h75};
        vt[3] = '{y: 10,  x: 100, we: 1'b0, addr: 16'h0042, wd: 8'h00, ack_x: BLANK_ONLY ? 802 : 102, rd: 8'h42};
        vt[4] = '{y: 11,  x: 805, we: 1'b1, addr: 16'h0042, wd: 8'h3C, ack_x: 807,                    rd: 8'h00};
        vt[5] = '{y: 600, x: 50,  we: 1'b0, addr: 16'h0042, wd: 8'h00, ack_x: 52,                     rd: 8'h3C};

        repeat (3) @(negedge clk);
        chk("reset outputs", {24'd0, cpu_ack, cpu_rdata, char_valid, char_code, char_line, mem_en, mem_we, mem_addr}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1; restart = 1'b0; chk_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            wait_xy(vt[i].x - 1, vt[i].y);
            cpu_go(vt[i].we, vt[i].addr, vt[i].wd);
            cpu_wait_ack(ax, rd);
            chk($sformatf("vec%0d ack_x", i), 64'(ax), 64'(vt[i].ack_x));
            if (!vt[i].we) chk($sformatf("vec%0d rdata", i), 64'(rd), 64'(vt[i].rd));
        end

        wait_xy(0, 0);
        chk("frame start fetch", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, BASE});
        wait_xy(2, 0);
        chk("first char", {char_valid, char_code}, {1'b1, ram_rd(BASE)});
        wait_xy(8, 0);
        chk("second fetch", 64'(mem_addr), 64'(16'h7001));
        wait_xy(0, 5);
        chk("line 5", {char_line, mem_addr}, {4'd5, 16'h7000});
        wait_xy(0, 10);
        chk("row 1 start", {char_line, mem_addr}, {4'd0, 16'h7064});

        for (int n = 0; n < 60; n++) begin
            logic [15:0] ra;
            ra = ($urandom_range(0, 1) == 0) ? (BASE + 16'($urandom_range(0, 255))) : 16'($urandom_range(0, 255));
            repeat ($urandom_range(0, 100)) @(posedge clk);
            cpu_go(1'($urandom_range(0, 1)), ra, 8'($urandom));
            cpu_wait_ack(ax, rd);
        end

        wait_xy(49, 600);
        cpu_go(1'b0, 16'h1234, 8'h00);
        @(posedge clk); #2;
        rst_n = 1'b0; restart = 1'b1; chk_en = 1'b0; cpu_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mid-access reset", {24'd0, cpu_ack, cpu_rdata, char_valid, char_code, char_line, mem_en, mem_we, mem_addr}, 64'd0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1; restart = 1'b0; chk_en = 1'b1;
        wait_xy(0, 0);
        chk("post-reset fetch", {mem_en, mem_addr}, {1'b1, BASE});
        wait_xy(16, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 16, VRAM address width; SCREEN_BASE, default 16'h7000, address of first character cell; COLS, default 100, characters per row; ROW_H, default 10, scanlines per character row; VIS_W, default 800, visible pixels; VIS_H, default 600, visible lines.
REQ-002 SHALL have ports: clk  in  1  pixel clock, single clock domain.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 counter_x, counter_y  in  11 each  raster position from the sync generator.
REQ-005 cpu_req  in  1  CPU access request, held until cpu_ack; cpu_we  in  1  1 = write; cpu_addr  in  ADDR_W; cpu_wdata  in  8.
REQ-006 cpu_ack  out  1  one-cycle completion pulse; cpu_rdata  out  8  read data, valid with cpu_ack.
REQ-007 mem_en  out  1; mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  8; mem_rdata  in  8  (synchronous RAM, read data one cycle after mem_en).
REQ-008 char_code  out  8; char_valid  out  1  one-cycle pulse; char_line  out  4  scanline within current character row.

Function
REQ-009 Video slot SHALL occur when counter_x[2:0]==0, counter_x<VIS_W, counter_y<VIS_H.
REQ-010 In a video slot: mem_en=1, mem_we=0, mem_addr=char_addr; char_valid pulses exactly 2 cycles after the slot cycle with char_code = registered mem_rdata.
REQ-011 char_addr SHALL increment by 1 after each video slot.
REQ-012 When counter_x==VIS_W and counter_y<VIS_H: char_addr reloads row_base; if char_line==ROW_H-1 then row_base += COLS, char_line <= 0, else char_line += 1.
REQ-013 When counter_x==0 and counter_y==0: row_base and char_addr <= SCREEN_BASE, char_line <= 0 (takes precedence over REQ-012).
REQ-014 Address generation SHALL use adders only; no multipliers; arithmetic wraps modulo 2^ADDR_W.
REQ-015 CPU FSM states: IDLE, ISSUE, DONE.
REQ-016 IDLE->ISSUE when cpu_req=1 and current cycle is not a video slot (and REQ-023 permits); in that cycle mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
REQ-017 ISSUE->DONE unconditionally; DONE cycle: cpu_ack=1, cpu_rdata=mem_rdata captured (write: rdata don't-care, keep last value).
REQ-018 DONE->IDLE unconditionally; a new request is not accepted in the DONE cycle (min 3-cycle CPU access).
REQ-019 Video slot SHALL always win; a CPU request coinciding with a slot waits; no in-flight access is ever aborted.
REQ-020 mem_en=0 and mem_we=0 in all other cycles; mem_we never asserted during a video slot.

Reset
REQ-021 On rst_n=0: FSM=IDLE, cpu_ack=0, cpu_rdata=0, char_valid=0, char_code=0, char_line=0, mem_en=0, mem_we=0, mem_addr=0, row_base=char_addr=SCREEN_BASE.
REQ-022 Reset mid-access SHALL drop the access with no cpu_ack; first frame after reset fetches from SCREEN_BASE.

Configuration
REQ-023 Macro VRAM_ARB_BLANK_ONLY_EN: defined -> CPU issue only when counter_x>=VIS_W or counter_y>=VIS_H; undefined -> CPU uses any non-slot cycle.

Structure
REQ-024 Shared package vram_pkg: FSM state encoding, SCREEN_BASE, COLS, ROW_H defaults.
REQ-025 One sub-module vram_addr_gen (char_addr, row_base, char_line per REQ-011..014); arbitration/FSM in top.

Verification
REQ-026 Frame start, counter_x 0..7, y=0 -> mem_addr=16'h7000 at x=0, char_valid at x=2, char_code=RAM[7000]; next slot x=8 addr 7001.
REQ-027 Line 9 end (y=9, x=800) -> next line first fetch addr 16'h7064; line 10 char_line=0; line 5 char_line=5, addr 16'h7000.
REQ-028 cpu_req write 8'hA5 to 16'h1234 at x=3 -> mem_we at x=3, cpu_ack at x=5; readback returns 8'hA5.
REQ-029 cpu_req at x=8 (slot) -> video issued at x=8, CPU issued x=9, ack x=11; video char_valid at x=10 unaffected.
REQ-030 With VRAM_ARB_BLANK_ONLY_EN, cpu_req at x=100,y=10 -> no ack until x=800; without macro ack at x=102.
REQ-031 rst_n low during ISSUE -> no cpu_ack, all outputs at reset values, next frame fetches 16'h7000.
